odd_p_serial_tx: RTL and testbench

Odd-parity serial frame transmitter: the sending end of the odd-parity checking path. It accepts a DATA_W-bit word over a valid/ready handshake and computes the odd-parity bit so that data plus parity carry an odd number of ones. It shifts out an asynchronous-style frame: start, data LSB first, parity, stop. The serial output feeds the parity-check receiver side of the design.

---
 rtl/odd_p_pkg.sv | 19 +
 rtl/odd_p_serial_tx_if.sv | 36 +++
 rtl/odd_p_bit_timer.sv | 38 +++
 rtl/odd_p_serial_tx.sv | 124 ++++++++++++
 tb/tb_odd_p_serial_tx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/odd_p_pkg.sv
// Shared types and constants for the odd-parity serial transmitter.
package odd_p_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Start, parity and stop bits wrapped around the payload.
  localparam int unsigned FrameOverhead = 3;

  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;
  localparam logic LineStop  = 1'b1;

endpackage

// File: rtl/odd_p_serial_tx_if.sv
// Handshake and serial-output bundle for odd_p_serial_tx.
// Optional macro ODD_P_TX_ERR_INJ_EN adds the inj_err request line.
interface odd_p_serial_tx_if #(
  parameter int unsigned DATA_W = 4
);
  logic [DATA_W-1:0] i;
  logic              valid;
  logic              ready;
  logic              tx;
  logic              p;
  logic              busy;
  logic              done;
`ifdef ODD_P_TX_ERR_INJ_EN
  logic              inj_err;

  modport master (
    output i, valid, inj_err,
    input  ready, tx, p, busy, done
  );

  modport slave (
    input  i, valid, inj_err,
    output ready, tx, p, busy, done
  );
`else
  modport master (
    output i, valid,
    input  ready, tx, p, busy, done
  );

  modport slave (
    input  i, valid,
    output ready, tx, p, busy, done
  );
`endif
endinterface

// File: rtl/odd_p_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and strobes bit_end
// on the last cycle of each period. clr restarts the period on frame accept.
module odd_p_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = en && (cnt_q == CntW'(CLKS_PER_BIT - 1));

  // Next count: clear wins, otherwise wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/odd_p_serial_tx.sv
// Odd-parity serial frame transmitter: start, data LSB first, parity, stop.
// Optional macro ODD_P_TX_ERR_INJ_EN: inj_err sampled on accept inverts the
// transmitted parity bit while p keeps showing the true odd parity.
module odd_p_serial_tx
  import odd_p_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  odd_p_serial_tx_if.slave  bus
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                p_q, p_d;
  logic                accept;
  logic                bit_end;
  logic                tx_par;

  assign accept = bus.valid && (state_q == StIdle);

  odd_p_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q != StIdle),
    .clr    (accept),
    .bit_end(bit_end)
  );

`ifdef ODD_P_TX_ERR_INJ_EN
  logic inj_q;

  // Error-injection request captured with the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (accept) begin
      inj_q <= bus.inj_err;
    end
  end

  assign tx_par = p_q ^ inj_q;
`else
  assign tx_par = p_q;
`endif

  // Frame sequencing, shift register and parity capture.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    p_d       = p_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = bus.i;
          p_d     = ~^bus.i;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; p resets to the parity of all-zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      p_q       <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      p_q       <= p_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.tx    = LineIdle;
    bus.ready = (state_q == StIdle);
    bus.busy  = (state_q != StIdle);
    bus.done  = (state_q == StStop) && bit_end;
    bus.p     = p_q;
    unique case (state_q)
      StIdle:   bus.tx = LineIdle;
      StStart:  bus.tx = LineStart;
      StData:   bus.tx = shift_q[0];
      StParity: bus.tx = tx_par;
      StStop:   bus.tx = LineStop;
      default:  bus.tx = LineIdle;
    endcase
  end

endmodule

// File: tb/tb_odd_p_serial_tx.sv
// Scoreboard bench for odd_p_serial_tx: stimulus pushes expected frames, a
// monitor pops one per observed frame and checks every cycle of it.
module tb_odd_p_serial_tx;
  import odd_p_pkg::*;

  localparam int unsigned DATA_W      = 4;
  localparam int unsigned CPB         = 4;
  localparam int unsigned NBITS       = DATA_W + FrameOverhead;
  localparam int unsigned FrameCycles = NBITS * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  odd_p_serial_tx_if #(.DATA_W(DATA_W)) bus ();

  odd_p_serial_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              p;
    logic              par_tx;
    logic              abort;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Call at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic exp_p, input logic inj,
                      input logic abort, input logic keep, output int unsigned acc_cyc);
    int unsigned n = 0;
    bus.i     = d;
    bus.valid = 1'b1;
`ifdef ODD_P_TX_ERR_INJ_EN
    bus.inj_err = inj;
`endif
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      bus.valid = 1'b0;
      acc_cyc = 0;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    sb.push_back('{d, exp_p, exp_p ^ inj, abort});
    @(negedge clk);
    if (!keep) bus.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((bus.busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || sb.size() != 0) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Monitor: one expected entry per frame, checked cycle by cycle.
  initial begin : monitor
    exp_t             e;
    logic [NBITS-1:0] bits;
    logic             aborted;
    logic             last;
    forever begin
      @(negedge clk);
      if (rst_n && bus.busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          while (bus.busy) @(negedge clk);
        end else begin
          e = sb.pop_front();
          bits = {LineStop, e.par_tx, e.data, LineStart};
          aborted = 1'b0;
          for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              last = (b == NBITS - 1) && (c == CPB - 1);
              chk("tx", bus.tx, bits[b]);
              chk("p", bus.p, e.p);
              chk("busy", bus.busy, 1);
              chk("done", bus.done, last);
            end
            if (aborted) break;
          end
          chk("abort", aborted, e.abort);
          if (aborted) begin
            chk("rst_tx", bus.tx, 1);
            chk("rst_busy", bus.busy, 0);
          end else begin
            @(negedge clk);
            chk("gap_tx", bus.tx, 1);
            chk("gap_ready", bus.ready, 1);
            chk("gap_done", bus.done, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned a0, a1, a2, t;
    bus.i     = '0;
    bus.valid = 1'b0;
`ifdef ODD_P_TX_ERR_INJ_EN
    bus.inj_err = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle state.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_tx", bus.tx, 1);
      chk("idle_ready", bus.ready, 1);
      chk("idle_busy", bus.busy, 0);
      chk("idle_p", bus.p, 1);
      chk("idle_done", bus.done, 0);
    end

    // Single frame.
    send(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, t);
    wait_idle();
    chk("p_after_0010", bus.p, 0);

    // Back-to-back with valid held high.
    send(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, a0);
    send(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, a1);
    send(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, a2);
    chk("b2b_gap1", a1 - a0, FrameCycles + 1);
    chk("b2b_gap2", a2 - a1, FrameCycles + 1);
    wait_idle();

    // valid pulse mid-frame is ignored.
    send(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, t);
    repeat (6) @(negedge clk);
    bus.i     = 4'b0101;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    wait_idle();
    chk("p_hold", bus.p, 0);

    // Reset mid-frame.
    send(4'b1100, 1'b1, 1'b0, 1'b1, 1'b0, t);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", bus.tx, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.ready, 1);
    chk("arst_done", bus.done, 0);
    chk("arst_p", bus.p, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, t);
    wait_idle();

    send(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, t);
    wait_idle();

`ifdef ODD_P_TX_ERR_INJ_EN
    // Injected parity error: line carries 0, p still 1.
    send(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, t);
    wait_idle();
    chk("inj_p", bus.p, 1);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
